rbcp_reg_bank: RTL and testbench
================================

Name: rbcp_reg_bank

Overview:
- Parametrised RBCP slave register bank on CLK_100M, sitting beside the SiTCP core's RBCP port.
- Provides NUM_RW read/write 32-bit words driven to fabric and NUM_RO read-only 32-bit status words sampled from fabric.
- Acknowledges both writes and reads with a configurable latency.
- Supports an offset-test mode: a write loads {addr word-aligned} + replicated data byte.
- Several instances with disjoint windows can share one RBCP bus by OR-ing their ACK and RD outputs.

Parameters:
- BASE_ADDR, 32'h0000_0000: window base; bits [ADDR_SPAN_BITS-1:0] are ignored.
- ADDR_SPAN_BITS, 8: window size is 2^ADDR_SPAN_BITS bytes; legal range 4..16.
- NUM_RW, 4: number of RW words; legal range 1..16.
- NUM_RO, 4: number of RO words; legal range 0..16; NUM_RW+NUM_RO <= 2^(ADDR_SPAN_BITS-2).
- RW_INIT, {NUM_RW{32'h0}}: flat reset value of the RW words.
- OFFSET_MODE, 0: 0 = byte write; 1 = offset-test write.
- ACK_LATENCY, 1: cycles from request to ACK; legal range 1..3.

Ports:
- CLK_100M  in  1  system clock.
- SiTCP_RESET  in  1  asynchronous, active-high reset.
- RBCP_ADDR  in  32  byte address.
- RBCP_WD  in  8  write data.
- RBCP_WE  in  1  write strobe, one-cycle pulse.
- RBCP_RE  in  1  read strobe, one-cycle pulse.
- RBCP_ACK  out  1  access acknowledge.
- RBCP_RD  out  8  read data; 0 when ACK is low.
- RW_REGS  out  32*NUM_RW  RW words; word k is at bits [32k+31:32k].
- RO_REGS  in  32*NUM_RO  status inputs, synchronous to CLK_100M.
- WR_STROBE  out  NUM_RW  bit k pulses for one cycle after word k changes.

Behaviour:
- Reset: SiTCP_RESET is asynchronous, active-high; the clock is CLK_100M. While reset is asserted:
  - RW words = RW_INIT.
  - RBCP_ACK = 0, RBCP_RD = 8'h00, WR_STROBE = 0.
  - ACK pipeline cleared; snapshot register = 0, snapshot tag invalid.
- Decode:
  - Hit = RBCP_ADDR[31:ADDR_SPAN_BITS] == BASE_ADDR[31:ADDR_SPAN_BITS].
  - Word index w = RBCP_ADDR[ADDR_SPAN_BITS-1:2]; byte lane b = RBCP_ADDR[1:0]. Lane 0 = bits [7:0], lane 3 = bits [31:24].
  - w < NUM_RW → RW word; NUM_RW <= w < NUM_RW+NUM_RO → RO word (w-NUM_RW); otherwise unmapped.
- Acknowledge:
  - A request (WE or RE) with Hit, sampled at cycle t, produces RBCP_ACK=1 for exactly one cycle at t+ACK_LATENCY.
  - RBCP_RD is valid in the same cycle as ACK and 0 in all other cycles.
  - The pipeline accepts one request per cycle; back-to-back requests each get their own ACK, in order.
  - Requests without Hit produce no ACK and leave RBCP_RD at 0.
- Write, Hit, RW word:
  - OFFSET_MODE=0: byte lane b of word w <= RBCP_WD at t+1.
  - OFFSET_MODE=1: whole word w <= {RBCP_ADDR[31:2],2'b00} + {4{RBCP_WD}} at t+1, 32-bit modulo. Lane b is ignored.
  - WR_STROBE[w] = 1 at t+1 for one cycle, even if the value is unchanged.
  - RBCP_RD = 0 in the ACK cycle.
- Write to an RO or unmapped word: no state change, no strobe, ACK still issued, RD = 0.
- Read, RW word: RD = lane b of word w as sampled at t.
- Read, RO word:
  - b == 0: capture all 32 bits of RO word into the snapshot register, set tag = w, return lane 0 of the live value.
  - b != 0 and tag == w: return lane b of the snapshot.
  - b != 0 and tag != w: return lane b of the live value.
- Read, unmapped word: RD = 8'h00, ACK still issued.
- WE and RE in the same cycle: treated as a write; one ACK; RD = 0.
- Reset asserted while an ACK is pending: the ACK is dropped, never emitted after reset release.
- Bus-sharing guarantee: outputs are registered and glitch-free; ACK and RD are 0 whenever the access is not this instance's, so wired-OR across instances is safe.

Test Plan:
- Default setup: BASE 0, SPAN 8, NUM_RW 4, NUM_RO 2, ACK_LATENCY 1, OFFSET_MODE 0.
- Byte write: WE, addr 0x0000_0005, WD 0x12 → RW_REGS word1 = 0x0000_1200 at t+1; WR_STROBE = 4'b0010 for one cycle; ACK at t+1 for one cycle with RD = 0.
- Readback: RE, addr 0x0000_0005 → ACK at t+1, RD = 0x12. Repeat with ACK_LATENCY 3 → ACK at t+3 only. Back-to-back REs at t and t+1 → ACKs at t+3 and t+4.
- RO snapshot: RO word0 = 0xAABBCCDD; RE 0x10 → RD 0xDD. Change input to 0x11223344; RE 0x13 → RD 0xAA (snapshot). Then RE 0x17 → RD 0x00 if RO word1 is 0 (live value, tag mismatch).
- Window decode: RE at 0x0000_0100 → no ACK, RD stays 0. RE at 0x0000_0040 (unmapped, in window) → ACK, RD 0x00. WE to RO addr 0x10 → ACK, RO path unaffected, no strobe.
- OFFSET_MODE 1: WE addr 0x0000_0006, WD 0x5A → word1 = 0x5A5A5A5E. Then RE 0x07 → RD 0x5A.
- Reset mid-operation: ACK_LATENCY 2, RE at t, SiTCP_RESET pulsed at t+1 → no ACK at t+2. RW words return to RW_INIT; WR_STROBE = 0.

Source files
------------

// File: rtl/rbcp_reg_bank.sv
// RBCP slave register bank: RW control words to fabric, RO status words with a
// lane-0 snapshot for coherent multi-byte reads, and a fixed-latency ACK pipe.
module rbcp_reg_bank #(
  parameter logic [31:0]          BASE_ADDR      = 32'h0000_0000,
  parameter int                   ADDR_SPAN_BITS = 8,
  parameter int                   NUM_RW         = 4,
  parameter int                   NUM_RO         = 4,
  parameter logic [32*NUM_RW-1:0] RW_INIT        = '0,
  parameter bit                   OFFSET_MODE    = 1'b0,
  parameter int                   ACK_LATENCY    = 1
) (
  input  logic                                      CLK_100M,
  input  logic                                      SiTCP_RESET,
  input  logic [31:0]                               RBCP_ADDR,
  input  logic [7:0]                                RBCP_WD,
  input  logic                                      RBCP_WE,
  input  logic                                      RBCP_RE,
  output logic                                      RBCP_ACK,
  output logic [7:0]                                RBCP_RD,
  output logic [32*NUM_RW-1:0]                      RW_REGS,
  input  logic [32*(NUM_RO > 0 ? NUM_RO : 1)-1:0]   RO_REGS,
  output logic [NUM_RW-1:0]                         WR_STROBE
);

  localparam int WW = ADDR_SPAN_BITS - 2;

  logic                   hit, rd_only, is_rw, is_ro;
  logic [WW-1:0]          word_idx;
  logic [31:0]            word_num;
  logic [1:0]             lane;
  logic [31:0]            rw_word, ro_live, rd_word, rd_shift;
  logic [31:0]            byte_mask, byte_word, offset_word, new_word;
  logic                   ack_d, wr_en, snap_cap, snap_hit;
  logic [7:0]             rd_d;

  logic [32*NUM_RW-1:0]   rw_q;
  logic [NUM_RW-1:0]      strobe_q;
  logic [31:0]            snap_q;
  logic [WW-1:0]          snap_tag;
  logic                   snap_valid;
  logic [ACK_LATENCY-1:0] ack_pipe;
  logic [7:0]             rd_pipe [ACK_LATENCY];

  assign hit      = RBCP_ADDR[31:ADDR_SPAN_BITS] == BASE_ADDR[31:ADDR_SPAN_BITS];
  assign word_idx = RBCP_ADDR[ADDR_SPAN_BITS-1:2];
  assign word_num = 32'(word_idx);
  assign lane     = RBCP_ADDR[1:0];
  assign is_rw    = word_num < NUM_RW;
  assign is_ro    = !is_rw && (word_num < NUM_RW + NUM_RO);
  // A simultaneous WE and RE is a write, so only RE alone takes the read path.
  assign rd_only  = RBCP_RE && !RBCP_WE;

  // NOTE: every always_comb output gets a default before the loops so that
  // an index matching no word leaves a defined value instead of a latch.
  always_comb begin
    rw_word = '0;
    for (int k = 0; k < NUM_RW; k++)
      if (word_num == k) rw_word = rw_q[32*k +: 32];
    ro_live = '0;
    for (int k = 0; k < NUM_RO; k++)
      if (word_num == NUM_RW + k) ro_live = RO_REGS[32*k +: 32];
  end

  assign snap_hit = snap_valid && (snap_tag == word_idx);

  always_comb begin
    rd_word = '0;
    if (is_rw)                               rd_word = rw_word;
    else if (is_ro && lane != 2'd0 && snap_hit) rd_word = snap_q;
    else if (is_ro)                          rd_word = ro_live;
  end

  assign rd_shift    = rd_word >> {lane, 3'b000};
  assign ack_d       = hit && (RBCP_WE || RBCP_RE);
  assign rd_d        = (hit && rd_only) ? rd_shift[7:0] : 8'h00;

  assign byte_mask   = 32'h0000_00FF << {lane, 3'b000};
  assign byte_word   = (rw_word & ~byte_mask) | ({24'h0, RBCP_WD} << {lane, 3'b000});
  assign offset_word = {RBCP_ADDR[31:2], 2'b00} + {4{RBCP_WD}};
  assign new_word    = OFFSET_MODE ? offset_word : byte_word;
  assign wr_en       = hit && RBCP_WE && is_rw;
  assign snap_cap    = hit && rd_only && is_ro && (lane == 2'd0);

  // NOTE: the RW words are plain flops rather than a RAM, so they take
  // RW_INIT on reset; sequential state always uses non-blocking assignment.
  always_ff @(posedge CLK_100M or posedge SiTCP_RESET) begin
    if (SiTCP_RESET) begin
      rw_q     <= RW_INIT;
      strobe_q <= '0;
    end else begin
      strobe_q <= '0;
      for (int k = 0; k < NUM_RW; k++) begin
        if (wr_en && word_num == k) begin
          rw_q[32*k +: 32] <= new_word;
          strobe_q[k]      <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_100M or posedge SiTCP_RESET) begin
    if (SiTCP_RESET) begin
      snap_q     <= '0;
      snap_tag   <= '0;
      snap_valid <= 1'b0;
    end else if (snap_cap) begin
      snap_q     <= ro_live;
      snap_tag   <= word_idx;
      snap_valid <= 1'b1;
    end
  end

  // Read data travels with its ACK bit, so RD is zero whenever ACK is low and
  // a pending ACK is simply flushed by reset.
  always_ff @(posedge CLK_100M or posedge SiTCP_RESET) begin
    if (SiTCP_RESET) begin
      ack_pipe <= '0;
      for (int i = 0; i < ACK_LATENCY; i++) rd_pipe[i] <= 8'h00;
    end else begin
      ack_pipe[0] <= ack_d;
      rd_pipe[0]  <= rd_d;
      for (int i = 1; i < ACK_LATENCY; i++) begin
        ack_pipe[i] <= ack_pipe[i-1];
        rd_pipe[i]  <= rd_pipe[i-1];
      end
    end
  end

  assign RBCP_ACK  = ack_pipe[ACK_LATENCY-1];
  assign RBCP_RD   = rd_pipe[ACK_LATENCY-1];
  assign RW_REGS   = rw_q;
  assign WR_STROBE = strobe_q;

endmodule

// File: tb/tb_rbcp_reg_bank.sv
// Bench for rbcp_reg_bank: three instances (latency 1/3/2, offset mode on the
// third) share one stimulus stream and are compared every cycle to a model.
module tb_rbcp_reg_bank;

  localparam logic [127:0] INIT2 = 128'hDEADBEEF_01234567_89ABCDEF_55AA55AA;

  logic         CLK_100M;
  logic         SiTCP_RESET;
  logic [31:0]  RBCP_ADDR;
  logic [7:0]   RBCP_WD;
  logic         RBCP_WE, RBCP_RE;
  logic [31:0]  ro_w [2];
  logic [63:0]  ro_bus;

  logic         ack0, ack1, ack2;
  logic [7:0]   rd0, rd1, rd2;
  logic [3:0]   strb0, strb1, strb2;
  logic [127:0] rw0, rw1, rw2;

  logic [2:0]         ack_out;
  logic [2:0][7:0]    rd_out;
  logic [2:0][3:0]    strb_out;
  logic [2:0][127:0]  rw_out;

  assign ro_bus   = {ro_w[1], ro_w[0]};
  assign ack_out  = {ack2, ack1, ack0};
  assign rd_out   = {rd2, rd1, rd0};
  assign strb_out = {strb2, strb1, strb0};
  assign rw_out   = {rw2, rw1, rw0};

  rbcp_reg_bank #(.NUM_RW(4), .NUM_RO(2), .ACK_LATENCY(1), .OFFSET_MODE(1'b0)) u0 (
    .CLK_100M(CLK_100M), .SiTCP_RESET(SiTCP_RESET), .RBCP_ADDR(RBCP_ADDR),
    .RBCP_WD(RBCP_WD), .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE), .RBCP_ACK(ack0),
    .RBCP_RD(rd0), .RW_REGS(rw0), .RO_REGS(ro_bus), .WR_STROBE(strb0));

  rbcp_reg_bank #(.NUM_RW(4), .NUM_RO(2), .ACK_LATENCY(3), .OFFSET_MODE(1'b0)) u1 (
    .CLK_100M(CLK_100M), .SiTCP_RESET(SiTCP_RESET), .RBCP_ADDR(RBCP_ADDR),
    .RBCP_WD(RBCP_WD), .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE), .RBCP_ACK(ack1),
    .RBCP_RD(rd1), .RW_REGS(rw1), .RO_REGS(ro_bus), .WR_STROBE(strb1));

  rbcp_reg_bank #(.NUM_RW(4), .NUM_RO(2), .ACK_LATENCY(2), .OFFSET_MODE(1'b1),
                  .RW_INIT(INIT2)) u2 (
    .CLK_100M(CLK_100M), .SiTCP_RESET(SiTCP_RESET), .RBCP_ADDR(RBCP_ADDR),
    .RBCP_WD(RBCP_WD), .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE), .RBCP_ACK(ack2),
    .RBCP_RD(rd2), .RW_REGS(rw2), .RO_REGS(ro_bus), .WR_STROBE(strb2));

  initial begin
    CLK_100M = 1'b0;
    forever #5 CLK_100M = ~CLK_100M;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  logic [31:0] mw [3][4];
  logic [31:0] snap [3];
  int          tag [3];
  bit          tag_ok [3];
  bit          sched_ack [3][4];
  logic [7:0]  sched_rd [3][4];
  logic [3:0]  exp_strb [3];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] x, input int b);
    logic [31:0] s;
    s = (x >> (8 * b)) & 32'hFF;
    return s[7:0];
  endfunction

  task model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        mw[i][k] = (i == 2) ? INIT2[32*k +: 32] : 32'h0;
        sched_ack[i][k] = 1'b0;
        sched_rd[i][k]  = 8'h00;
      end
      snap[i] = 32'h0; tag[i] = 0; tag_ok[i] = 1'b0; exp_strb[i] = 4'h0;
    end
  endtask

  always @(posedge CLK_100M or posedge SiTCP_RESET) begin
    if (SiTCP_RESET) begin
      model_reset();
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
        logic [7:0]  rd;
        logic [31:0] live;
        int w, b, slot;
        sched_ack[i][(cyc + 3) % 4] = 1'b0;
        sched_rd[i][(cyc + 3) % 4]  = 8'h00;
        exp_strb[i] = 4'h0;
        if (RBCP_ADDR[31:8] == 24'h0 && (RBCP_WE || RBCP_RE)) begin
          w  = int'(RBCP_ADDR[7:2]);
          b  = int'(RBCP_ADDR[1:0]);
          rd = 8'h00;
          if (RBCP_WE) begin
            if (w < 4) begin
              if (i == 2) mw[i][w] = {RBCP_ADDR[31:2], 2'b00} + {4{RBCP_WD}};
              else mw[i][w] = (mw[i][w] & ~(32'hFF << (8 * b))) | (32'(RBCP_WD) << (8 * b));
              exp_strb[i][w] = 1'b1;
            end
          end else if (w < 4) begin
            rd = byte_of(mw[i][w], b);
          end else if (w < 6) begin
            live = ro_w[w - 4];
            if (b == 0) begin
              snap[i] = live; tag[i] = w; tag_ok[i] = 1'b1;
              rd = byte_of(live, 0);
            end else if (tag_ok[i] && tag[i] == w) begin
              rd = byte_of(snap[i], b);
            end else begin
              rd = byte_of(live, b);
            end
          end
          slot = (cyc + lat_of(i) - 1) % 4;
          sched_ack[i][slot] = 1'b1;
          sched_rd[i][slot]  = rd;
        end
      end
    end
  end

  // Single compare process: every cycle, every instance, every output.
  always @(negedge CLK_100M) begin
    for (int i = 0; i < 3; i++) begin
      logic [127:0] exp_rw;
      exp_rw = '0;
      for (int k = 0; k < 4; k++) exp_rw[32*k +: 32] = mw[i][k];
      check($sformatf("u%0d_ack@%0d", i, cyc), 128'(ack_out[i]), 128'(sched_ack[i][cyc % 4]));
      check($sformatf("u%0d_rd@%0d", i, cyc), 128'(rd_out[i]), 128'(sched_rd[i][cyc % 4]));
      check($sformatf("u%0d_strobe@%0d", i, cyc), 128'(strb_out[i]), 128'(exp_strb[i]));
      check($sformatf("u%0d_rw@%0d", i, cyc), rw_out[i], exp_rw);
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic we, input logic re, input logic [31:0] addr,
                       input logic [7:0] wd);
    RBCP_WE = we; RBCP_RE = re; RBCP_ADDR = addr; RBCP_WD = wd;
    @(negedge CLK_100M);
    RBCP_WE = 1'b0; RBCP_RE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_100M);
  endtask

  initial begin
    SiTCP_RESET = 1'b0;
    RBCP_WE = 1'b0; RBCP_RE = 1'b0; RBCP_ADDR = 32'h0; RBCP_WD = 8'h00;
    ro_w[0] = 32'h0; ro_w[1] = 32'h0;
    #1 SiTCP_RESET = 1'b1;
    idle(2);
    check("reset_ack0", 128'(ack0), 128'(0));
    check("reset_rd0", 128'(rd0), 128'(0));
    check("reset_rw0", rw0, 128'h0);
    check("reset_rw2", rw2, INIT2);
    #2 SiTCP_RESET = 1'b0;
    idle(1);

    // Byte write
    apply(1'b1, 1'b0, 32'h0000_0005, 8'h12);
    check("bw_word1", 128'(rw0[63:32]), 128'h0000_1200);
    check("bw_strobe", 128'(strb0), 128'(4'b0010));
    check("bw_ack", 128'(ack0), 128'(1));
    check("bw_rd", 128'(rd0), 128'(0));
    check("bw_off_word1", 128'(rw2[63:32]), 128'h1212_1216);
    idle(1);
    check("bw_strobe_clr", 128'(strb0), 128'(0));
    check("bw_ack_clr", 128'(ack0), 128'(0));
    idle(2);

    // Readback, latency 1 and latency 3
    apply(1'b0, 1'b1, 32'h0000_0005, 8'h00);
    check("rb_ack", 128'(ack0), 128'(1));
    check("rb_rd", 128'(rd0), 128'h12);
    check("rb_l3_t1", 128'(ack1), 128'(0));
    idle(1);
    check("rb_l3_t2", 128'(ack1), 128'(0));
    idle(1);
    check("rb_l3_t3", 128'(ack1), 128'(1));
    check("rb_l3_rd", 128'(rd1), 128'h12);

    // Back-to-back reads on the latency-3 instance
    apply(1'b0, 1'b1, 32'h0000_0005, 8'h00);
    apply(1'b0, 1'b1, 32'h0000_0005, 8'h00);
    check("b2b_early", 128'(ack1), 128'(0));
    idle(1);
    check("b2b_ack1", 128'(ack1), 128'(1));
    idle(1);
    check("b2b_ack2", 128'(ack1), 128'(1));
    check("b2b_rd2", 128'(rd1), 128'h12);
    idle(1);
    check("b2b_done", 128'(ack1), 128'(0));

    // RO snapshot
    ro_w[0] = 32'hAABB_CCDD; ro_w[1] = 32'h0;
    apply(1'b0, 1'b1, 32'h0000_0010, 8'h00);
    check("ro_lane0", 128'(rd0), 128'hDD);
    ro_w[0] = 32'h1122_3344;
    apply(1'b0, 1'b1, 32'h0000_0013, 8'h00);
    check("ro_snap_lane3", 128'(rd0), 128'hAA);
    apply(1'b0, 1'b1, 32'h0000_0017, 8'h00);
    check("ro_live_w1", 128'(rd0), 128'h00);
    check("ro_live_ack", 128'(ack0), 128'(1));

    // Window decode
    apply(1'b0, 1'b1, 32'h0000_0100, 8'h00);
    check("miss_ack", 128'(ack0), 128'(0));
    check("miss_rd", 128'(rd0), 128'(0));
    apply(1'b0, 1'b1, 32'h0000_0040, 8'h00);
    check("unmapped_ack", 128'(ack0), 128'(1));
    check("unmapped_rd", 128'(rd0), 128'(0));
    apply(1'b1, 1'b0, 32'h0000_0010, 8'hFF);
    check("ro_wr_ack", 128'(ack0), 128'(1));
    check("ro_wr_strobe", 128'(strb0), 128'(0));
    check("ro_wr_rw", rw0, 128'h00000000_00000000_00001200_00000000);
    apply(1'b0, 1'b1, 32'h0000_0010, 8'h00);
    check("ro_wr_live", 128'(rd0), 128'h44);

    // WE and RE together act as a write
    apply(1'b1, 1'b1, 32'h0000_0009, 8'h77);
    check("wr_rd_ack", 128'(ack0), 128'(1));
    check("wr_rd_rd", 128'(rd0), 128'(0));
    check("wr_rd_strobe", 128'(strb0), 128'(4'b0100));
    check("wr_rd_word2", 128'(rw0[95:64]), 128'h0000_7700);
    idle(3);

    // Offset-test write
    apply(1'b1, 1'b0, 32'h0000_0006, 8'h5A);
    check("off_word1", 128'(rw2[63:32]), 128'h5A5A_5A5E);
    apply(1'b0, 1'b1, 32'h0000_0007, 8'h00);
    check("off_wr_rd", 128'(rd2), 128'(0));
    idle(1);
    check("off_rd_ack", 128'(ack2), 128'(1));
    check("off_rd", 128'(rd2), 128'h5A);
    idle(2);

    // Reset with ACKs pending
    apply(1'b0, 1'b1, 32'h0000_0005, 8'h00);
    #2 SiTCP_RESET = 1'b1;
    idle(1);
    check("rst_ack2", 128'(ack2), 128'(0));
    check("rst_rw2", rw2, INIT2);
    check("rst_rw0", rw0, 128'h0);
    check("rst_strobe", 128'(strb2), 128'(0));
    #2 SiTCP_RESET = 1'b0;
    idle(1);
    check("rst_ack2_after", 128'(ack2), 128'(0));
    check("rst_ack1_after", 128'(ack1), 128'(0));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [5:0] w;
      r = int'($urandom_range(0, 7));
      RBCP_WE = (r < 2) || (r == 5);
      RBCP_RE = (r >= 2) && (r <= 5);
      w = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 5));
      RBCP_ADDR = {(($urandom_range(0, 5) == 0) ? 24'($urandom) : 24'h0), w, 2'($urandom)};
      RBCP_WD = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ro_w[$urandom_range(0, 1)] = $urandom;
      @(negedge CLK_100M);
      if ($urandom_range(0, 299) == 0) begin
        #2 SiTCP_RESET = 1'b1;
        @(negedge CLK_100M);
        #2 SiTCP_RESET = 1'b0;
      end
    end
    RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
